// File: rtl/ex_forward_unit.sv
// ex_forward_unit: operand forwarding and load-use hazard unit for the EX stage.
// Forward selects are decided in ID from the in-flight EX/MEM destination
// records and registered into EX. The operand mux after that register is
// purely combinational. A load-use hazard holds ID for LOAD_LAT cycles.
// Optional statistics counters are built only when FWD_STATS_EN is defined.
module ex_forward_unit #(
  parameter int XLEN     = 32,
  parameter int NUM_SRC  = 2,
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_valid,
  input  logic [REG_AW-1:0]         id_rd,
  input  logic                      id_wr_en,
  input  logic                      id_is_load,
  input  logic [NUM_SRC*REG_AW-1:0] id_rs,
  input  logic                      flush,
  input  logic [NUM_SRC*XLEN-1:0]   ex_reg_data,
  input  logic [XLEN-1:0]           mem_alu_out,
  input  logic [XLEN-1:0]           wb_result,
  output logic                      stall,
  output logic [NUM_SRC*2-1:0]      ex_fsel,
  output logic [NUM_SRC*XLEN-1:0]   ex_fwd_data,
  output logic [31:0]               stall_cycles,
  output logic [31:0]               fwd_count
);

  // Destination tracking. The WB record is not stored: a producer seen in MEM
  // at decode time sits in WB when its consumer reaches EX, and that fact is
  // already captured by the registered 10 select. is_load matters only in EX.
  logic              ex_valid_reg;
  logic              ex_wr_en_reg;
  logic              ex_is_load_reg;
  logic [REG_AW-1:0] ex_rd_reg;
  logic              mem_valid_reg;
  logic              mem_wr_en_reg;
  logic [REG_AW-1:0] mem_rd_reg;

  logic [1:0]             cnt_reg;
  logic [NUM_SRC*2-1:0]   ex_fsel_reg;
  logic [NUM_SRC*2-1:0]   fsel_next;
  logic [NUM_SRC-1:0]     ex_hit;
  logic [NUM_SRC-1:0]     mem_hit;
  logic [NUM_SRC-1:0]     load_hit;
  logic                   hazard;
  logic                   enter_ex;

  // Per-operand match against the in-flight producers and the operand mux.
  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
      logic [REG_AW-1:0] rs;
      logic [1:0]        sel;
      assign rs          = id_rs[gi*REG_AW +: REG_AW];
      assign ex_hit[gi]  = ex_valid_reg & ex_wr_en_reg & (ex_rd_reg == rs) & (rs != '0);
      assign mem_hit[gi] = mem_valid_reg & mem_wr_en_reg & (mem_rd_reg == rs) & (rs != '0);
      assign load_hit[gi] = ex_hit[gi] & ex_is_load_reg;
      // A loaded value is not available from the MEM ALU output, so an EX
      // load never produces 01; the stall covers it instead.
      assign fsel_next[gi*2 +: 2] = (ex_hit[gi] & ~ex_is_load_reg) ? 2'b01 :
                                    mem_hit[gi]                    ? 2'b10 : 2'b00;
      assign sel = ex_fsel_reg[gi*2 +: 2];
      assign ex_fwd_data[gi*XLEN +: XLEN] = (sel == 2'b01) ? mem_alu_out :
                                            (sel == 2'b10) ? wb_result   :
                                            ex_reg_data[gi*XLEN +: XLEN];
    end
  endgenerate

  assign hazard   = id_valid & (|load_hit);
  assign stall    = (cnt_reg != 2'd0) | (hazard & (cnt_reg == 2'd0));
  assign enter_ex = id_valid & ~stall & ~flush;
  assign ex_fsel  = ex_fsel_reg;

  // Shift the tracking records every cycle; a bubble enters EX unless ID advances.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_reg   <= 1'b0;
      ex_wr_en_reg   <= 1'b0;
      ex_is_load_reg <= 1'b0;
      ex_rd_reg      <= '0;
      mem_valid_reg  <= 1'b0;
      mem_wr_en_reg  <= 1'b0;
      mem_rd_reg     <= '0;
      ex_fsel_reg    <= '0;
    end else begin
      mem_valid_reg  <= ex_valid_reg;
      mem_wr_en_reg  <= ex_wr_en_reg;
      mem_rd_reg     <= ex_rd_reg;
      ex_valid_reg   <= enter_ex;
      ex_wr_en_reg   <= id_wr_en;
      ex_is_load_reg <= id_is_load;
      ex_rd_reg      <= id_rd;
      ex_fsel_reg    <= enter_ex ? fsel_next : '0;
    end
  end

  // Load-use stall counter: the hazard cycle itself is the first stall cycle,
  // the counter covers the remaining LOAD_LAT-1. A flush abandons the wait.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= 2'd0;
    end else if (flush) begin
      cnt_reg <= 2'd0;
    end else if (cnt_reg != 2'd0) begin
      cnt_reg <= cnt_reg - 2'd1;
    end else if (hazard) begin
      cnt_reg <= 2'(LOAD_LAT - 1);
    end
  end

`ifdef FWD_STATS_EN
  logic [31:0] stall_cycles_reg;
  logic [31:0] fwd_count_reg;
  logic [31:0] nz_count;

  // Number of operands of the ID instruction that will be forwarded.
  always_comb begin
    nz_count = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      nz_count = nz_count + 32'(|fsel_next[i*2 +: 2]);
    end
  end

  // Free-running statistics, wrapping at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_reg <= '0;
      fwd_count_reg    <= '0;
    end else begin
      if (stall) stall_cycles_reg <= stall_cycles_reg + 32'd1;
      if (enter_ex) fwd_count_reg <= fwd_count_reg + nz_count;
    end
  end

  assign stall_cycles = stall_cycles_reg;
  assign fwd_count    = fwd_count_reg;
`else
  assign stall_cycles = '0;
  assign fwd_count    = '0;
`endif

endmodule

// File: tb/tb_ex_forward_unit.sv
// Testbench for ex_forward_unit: three instances (LOAD_LAT 1, 2, 3) share one
// set of inputs. Directed scenarios check fixed expected values; a random run
// is checked against a record-shifting reference model per instance.
module tb_ex_forward_unit;

  localparam int XLEN = 32;
  localparam int NS   = 2;
  localparam int AW   = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              id_valid;
  logic [AW-1:0]     id_rd;
  logic              id_wr_en;
  logic              id_is_load;
  logic [NS*AW-1:0]  id_rs;
  logic              flush;
  logic [NS*XLEN-1:0] ex_reg_data;
  logic [XLEN-1:0]   mem_alu_out;
  logic [XLEN-1:0]   wb_result;

  logic              stall_o [3];
  logic [NS*2-1:0]   fsel_o  [3];
  logic [NS*XLEN-1:0] data_o [3];
  logic [31:0]       sc_o    [3];
  logic [31:0]       fc_o    [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      ex_forward_unit #(
        .XLEN(XLEN), .NUM_SRC(NS), .REG_AW(AW), .LOAD_LAT(gi + 1)
      ) u_dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rd(id_rd),
        .id_wr_en(id_wr_en), .id_is_load(id_is_load), .id_rs(id_rs),
        .flush(flush), .ex_reg_data(ex_reg_data), .mem_alu_out(mem_alu_out),
        .wb_result(wb_result), .stall(stall_o[gi]), .ex_fsel(fsel_o[gi]),
        .ex_fwd_data(data_o[gi]), .stall_cycles(sc_o[gi]), .fwd_count(fc_o[gi])
      );
    end
  endgenerate

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rd, input logic wr,
                        input logic ld, input logic [4:0] rs0, input logic [4:0] rs1);
    id_valid   = v;
    id_rd      = rd;
    id_wr_en   = wr;
    id_is_load = ld;
    id_rs      = {rs1, rs0};
  endtask

  task automatic idle(input int n);
    set_id(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0);
    flush = 1'b0;
    rst   = 1'b0;
    repeat (n) tick();
  endtask

  // ---------------- directed scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    flush = 1'b0;
    set_id(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0);
    ex_reg_data = {$urandom, $urandom};
    mem_alu_out = $urandom;
    wb_result   = $urandom;
    tick();
    tick();
    rst = 1'b0;
    set_id(1'b1, 5'd3, 1'b1, 1'b0, 5'd1, 5'd2);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (stall_o[k] !== 1'b0) begin
        errors++; $display("FAIL reset_stall inst %0d got %b exp 0", k, stall_o[k]);
      end
      checks++;
      if (fsel_o[k] !== 4'b0000) begin
        errors++; $display("FAIL reset_fsel inst %0d got %b exp 0000", k, fsel_o[k]);
      end
      checks++;
      if (data_o[k] !== ex_reg_data) begin
        errors++; $display("FAIL reset_data inst %0d got %h exp %h", k, data_o[k], ex_reg_data);
      end
      checks++;
      if (sc_o[k] !== 32'd0 || fc_o[k] !== 32'd0) begin
        errors++; $display("FAIL reset_stats inst %0d got %0d/%0d exp 0/0", k, sc_o[k], fc_o[k]);
      end
    end
    tick();
  endtask

  task automatic test_ex_forward();
    idle(4);
    set_id(1'b1, 5'd5, 1'b1, 1'b0, 5'd1, 5'd2);   // add x5,x1,x2
    tick();
    set_id(1'b1, 5'd6, 1'b1, 1'b0, 5'd5, 5'd7);   // add x6,x5,x7
    tick();
    set_id(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0);
    mem_alu_out = 32'h0000_1234;
    wb_result   = 32'h5555_5555;
    ex_reg_data = {32'hAAAA_0001, 32'hAAAA_0000};
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (fsel_o[k] !== 4'b0001) begin
        errors++; $display("FAIL exfwd_fsel inst %0d got %b exp 0001", k, fsel_o[k]);
      end
      checks++;
      if (data_o[k] !== {32'hAAAA_0001, 32'h0000_1234}) begin
        errors++; $display("FAIL exfwd_data inst %0d got %h exp aaaa000100001234", k, data_o[k]);
      end
    end
    tick();
  endtask

  task automatic test_mem_wb_forward();
    // producer two ahead -> WB select
    idle(4);
    set_id(1'b1, 5'd5, 1'b1, 1'b0, 5'd1, 5'd2);
    tick();
    set_id(1'b1, 5'd9, 1'b1, 1'b0, 5'd1, 5'd2);
    tick();
    set_id(1'b1, 5'd6, 1'b1, 1'b0, 5'd5, 5'd0);
    tick();
    set_id(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0);
    wb_result   = 32'h0000_BEEF;
    mem_alu_out = 32'h0000_1111;
    ex_reg_data = {32'h2222_2222, 32'h3333_3333};
    @(negedge clk);
    checks++;
    if (fsel_o[0] !== 4'b0010) begin
      errors++; $display("FAIL wbfwd_fsel got %b exp 0010", fsel_o[0]);
    end
    checks++;
    if (data_o[0][31:0] !== 32'h0000_BEEF) begin
      errors++; $display("FAIL wbfwd_data got %h exp 0000beef", data_o[0][31:0]);
    end
    // producers in both MEM and WB -> younger (01) wins
    idle(4);
    set_id(1'b1, 5'd5, 1'b1, 1'b0, 5'd1, 5'd2);
    tick();
    set_id(1'b1, 5'd5, 1'b1, 1'b0, 5'd1, 5'd2);
    tick();
    set_id(1'b1, 5'd6, 1'b1, 1'b0, 5'd5, 5'd0);
    tick();
    set_id(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0);
    @(negedge clk);
    checks++;
    if (fsel_o[0] !== 4'b0001) begin
      errors++; $display("FAIL young_fsel got %b exp 0001", fsel_o[0]);
    end
    checks++;
    if (data_o[0][31:0] !== 32'h0000_1111) begin
      errors++; $display("FAIL young_data got %h exp 00001111", data_o[0][31:0]);
    end
    tick();
  endtask

  task automatic test_x0();
    idle(4);
    set_id(1'b1, 5'd0, 1'b1, 1'b0, 5'd1, 5'd2);   // writes x0
    tick();
    set_id(1'b1, 5'd6, 1'b1, 1'b0, 5'd0, 5'd0);
    tick();
    set_id(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0);
    mem_alu_out = 32'hDEAD_0000;
    ex_reg_data = {32'h0000_0077, 32'h0000_0066};
    @(negedge clk);
    checks++;
    if (fsel_o[0] !== 4'b0000) begin
      errors++; $display("FAIL x0_fsel got %b exp 0000", fsel_o[0]);
    end
    checks++;
    if (data_o[0] !== {32'h0000_0077, 32'h0000_0066}) begin
      errors++; $display("FAIL x0_data got %h exp 0000007700000066", data_o[0]);
    end
    tick();
  endtask

  task automatic test_load_use_l1();
    idle(4);
    set_id(1'b1, 5'd5, 1'b1, 1'b1, 5'd1, 5'd2);   // lw x5
    tick();
    set_id(1'b1, 5'd6, 1'b1, 1'b0, 5'd5, 5'd5);   // add x6,x5,x5 held in ID
    @(negedge clk);
    checks++;
    if (stall_o[0] !== 1'b1) begin
      errors++; $display("FAIL lu1_stall_c0 got %b exp 1", stall_o[0]);
    end
    tick();
    @(negedge clk);
    checks++;
    if (stall_o[0] !== 1'b0) begin
      errors++; $display("FAIL lu1_stall_c1 got %b exp 0", stall_o[0]);
    end
    checks++;
    if (fsel_o[0] !== 4'b0000) begin
      errors++; $display("FAIL lu1_bubble_fsel got %b exp 0000", fsel_o[0]);
    end
    tick();
    set_id(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0);
    @(negedge clk);
    checks++;
    if (fsel_o[0] !== 4'b1010) begin
      errors++; $display("FAIL lu1_consumer_fsel got %b exp 1010", fsel_o[0]);
    end
    tick();
  endtask

  task automatic test_load_use_l3();
    idle(4);
    set_id(1'b1, 5'd5, 1'b1, 1'b1, 5'd1, 5'd2);
    tick();
    set_id(1'b1, 5'd6, 1'b1, 1'b0, 5'd5, 5'd5);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (stall_o[2] !== 1'b1) begin
        errors++; $display("FAIL lu3_stall cycle %0d got %b exp 1", c, stall_o[2]);
      end
      tick();
    end
    @(negedge clk);
    checks++;
    if (stall_o[2] !== 1'b0) begin
      errors++; $display("FAIL lu3_release got %b exp 0", stall_o[2]);
    end
    tick();
    set_id(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0);
    @(negedge clk);
    checks++;
    if (fsel_o[2] !== 4'b0000) begin
      errors++; $display("FAIL lu3_consumer_fsel got %b exp 0000", fsel_o[2]);
    end
    tick();
  endtask

  task automatic test_flush_mid_stall();
    idle(4);
    set_id(1'b1, 5'd5, 1'b1, 1'b1, 5'd1, 5'd2);
    tick();
    set_id(1'b1, 5'd6, 1'b1, 1'b0, 5'd5, 5'd5);
    @(negedge clk);
    checks++;
    if (stall_o[1] !== 1'b1) begin
      errors++; $display("FAIL fl_stall_first got %b exp 1", stall_o[1]);
    end
    #1 flush = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge clk);
    checks++;
    if (stall_o[1] !== 1'b0) begin
      errors++; $display("FAIL fl_stall_after got %b exp 0", stall_o[1]);
    end
    checks++;
    if (fsel_o[1] !== 4'b0000) begin
      errors++; $display("FAIL fl_bubble_fsel got %b exp 0000", fsel_o[1]);
    end
    tick();
  endtask

  task automatic test_rst_mid_stall();
    idle(4);
    set_id(1'b1, 5'd5, 1'b1, 1'b1, 5'd1, 5'd2);
    tick();
    set_id(1'b1, 5'd6, 1'b1, 1'b0, 5'd5, 5'd5);
    @(negedge clk);
    checks++;
    if (stall_o[1] !== 1'b1) begin
      errors++; $display("FAIL rs_stall_first got %b exp 1", stall_o[1]);
    end
    #1 rst = 1'b1;
    tick();
    rst = 1'b0;
    ex_reg_data = {$urandom, $urandom};
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (stall_o[k] !== 1'b0 || fsel_o[k] !== 4'b0000) begin
        errors++; $display("FAIL rs_after inst %0d got stall %b fsel %b exp 0 0000", k, stall_o[k], fsel_o[k]);
      end
      checks++;
      if (data_o[k] !== ex_reg_data) begin
        errors++; $display("FAIL rs_data inst %0d got %h exp %h", k, data_o[k], ex_reg_data);
      end
      checks++;
      if (sc_o[k] !== 32'd0 || fc_o[k] !== 32'd0) begin
        errors++; $display("FAIL rs_stats inst %0d got %0d/%0d exp 0/0", k, sc_o[k], fc_o[k]);
      end
    end
    tick();
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit         valid;
    bit         wr;
    bit         ld;
    logic [4:0] rd;
  } mrec_t;

  mrec_t       m_ex [3];
  mrec_t       m_mem [3];
  logic [1:0]  m_fsel [3][NS];
  int          stall_until [3];
  int unsigned m_sc [3];
  int unsigned m_fc [3];

  function automatic bit writes(input mrec_t r, input logic [4:0] s);
    return r.valid && r.wr && (r.rd == s) && (s != 5'd0);
  endfunction

  task automatic test_random(input int n);
    int cyc;
    logic [4:0] rs [NS];
    rst = 1'b1;
    flush = 1'b0;
    set_id(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      m_ex[k]  = '{valid: 1'b0, wr: 1'b0, ld: 1'b0, rd: 5'd0};
      m_mem[k] = '{valid: 1'b0, wr: 1'b0, ld: 1'b0, rd: 5'd0};
      for (int i = 0; i < NS; i++) m_fsel[k][i] = 2'b00;
      stall_until[k] = -1;
      m_sc[k] = 0;
      m_fc[k] = 0;
    end
    cyc = 0;
    for (int c = 0; c < n; c++) begin
      set_id(($urandom % 8) != 0, 5'($urandom % 4), ($urandom % 4) != 0,
             ($urandom % 3) == 0, 5'($urandom % 4), 5'($urandom % 4));
      flush       = ($urandom % 10) == 0;
      ex_reg_data = {$urandom, $urandom};
      mem_alu_out = $urandom;
      wb_result   = $urandom;
      for (int i = 0; i < NS; i++) rs[i] = id_rs[i*AW +: AW];
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        bit hz, st, enter;
        logic [NS*XLEN-1:0] exp_data;
        logic [NS*2-1:0]    exp_fsel;
        logic [1:0]         nf [NS];
        int unsigned        nz;
        logic [31:0]        exp_sc, exp_fc;
        hz = 1'b0;
        for (int i = 0; i < NS; i++)
          if (id_valid && m_ex[k].ld && writes(m_ex[k], rs[i])) hz = 1'b1;
        st = (cyc <= stall_until[k]) || hz;
        for (int i = 0; i < NS; i++) begin
          exp_fsel[i*2 +: 2] = m_fsel[k][i];
          case (m_fsel[k][i])
            2'b01:   exp_data[i*XLEN +: XLEN] = mem_alu_out;
            2'b10:   exp_data[i*XLEN +: XLEN] = wb_result;
            default: exp_data[i*XLEN +: XLEN] = ex_reg_data[i*XLEN +: XLEN];
          endcase
        end
`ifdef FWD_STATS_EN
        exp_sc = m_sc[k];
        exp_fc = m_fc[k];
`else
        exp_sc = 32'd0;
        exp_fc = 32'd0;
`endif
        checks++;
        if (stall_o[k] !== st) begin
          errors++; $display("FAIL rnd_stall inst %0d cyc %0d got %b exp %b", k, cyc, stall_o[k], st);
        end
        checks++;
        if (fsel_o[k] !== exp_fsel) begin
          errors++; $display("FAIL rnd_fsel inst %0d cyc %0d got %b exp %b", k, cyc, fsel_o[k], exp_fsel);
        end
        checks++;
        if (data_o[k] !== exp_data) begin
          errors++; $display("FAIL rnd_data inst %0d cyc %0d got %h exp %h", k, cyc, data_o[k], exp_data);
        end
        checks++;
        if (sc_o[k] !== exp_sc || fc_o[k] !== exp_fc) begin
          errors++; $display("FAIL rnd_stats inst %0d cyc %0d got %0d/%0d exp %0d/%0d",
                             k, cyc, sc_o[k], fc_o[k], exp_sc, exp_fc);
        end
        // advance the model across the coming clock edge
        enter = id_valid && !st && !flush;
        nz = 0;
        for (int i = 0; i < NS; i++) begin
          nf[i] = 2'b00;
          if (enter) begin
            if (writes(m_ex[k], rs[i]) && !m_ex[k].ld) nf[i] = 2'b01;
            else if (writes(m_mem[k], rs[i]))          nf[i] = 2'b10;
          end
          if (nf[i] != 2'b00) nz++;
        end
        if (st) m_sc[k]++;
        if (enter) m_fc[k] += nz;
        if (flush) stall_until[k] = cyc;
        else if (hz && cyc > stall_until[k]) stall_until[k] = cyc + k;  // LOAD_LAT-1 == k
        m_mem[k] = m_ex[k];
        if (enter) m_ex[k] = '{valid: 1'b1, wr: id_wr_en, ld: id_is_load, rd: id_rd};
        else       m_ex[k] = '{valid: 1'b0, wr: 1'b0, ld: 1'b0, rd: 5'd0};
        for (int i = 0; i < NS; i++) m_fsel[k][i] = nf[i];
      end
      cyc++;
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    set_id(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0);
    ex_reg_data = '0;
    mem_alu_out = '0;
    wb_result   = '0;
    test_reset();
    test_ex_forward();
    test_mem_wb_forward();
    test_x0();
    test_load_use_l1();
    test_load_use_l3();
    test_flush_mid_stall();
    test_rst_mid_stall();
    test_random(400);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
